multicycle_main_cu: RTL
=======================

// Module: multicycle_main_cu
// PURPOSE
//  Multi-cycle MIPS main control FSM. It produces ALUOp[2:0] for the ALU control
//  decoder and consumes its JumpReg answer. It decodes Opcode from the instruction
//  register and sequences fetch/decode/execute/memory/writeback, stalling on mem_ready.
//  Sits between IR/memory and the datapath muxes, register file and PC enables.
// PARAMETERS
//  STATE_W   4      state register width; 13 states used
//  OP_RTYPE  6'h00  R-type opcode      | OP_LW   6'h23  load word
//  OP_SW     6'h2B  store word         | OP_BEQ  6'h04  branch equal
//  OP_J      6'h02  jump               | OP_ADDI 6'h08  add immediate
//  OP_ANDI   6'h0C  and immediate      | OP_ORI  6'h0D  or immediate
//  OP_BNE    6'h05  branch not equal (used only with BNE_EN)
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high reset
//  Opcode       in   6  IR[31:26]; stable from DECODE to end of instruction
//  JumpReg      in   1  from ALU control decoder; 1 = R-type is jr
//  mem_ready    in   1  memory done; sampled only in FETCH, MEMRD, MEMWR
//  MemRead, MemWrite, IorD, IRWrite   out 1  memory/IR controls
//  RegDst, MemtoReg, RegWrite         out 1  register-file controls
//  ALUSrcA out 1; ALUSrcB out 2 (00 reg,01 const4,10 imm,11 imm<<2); ZeroExt out 1
//  ALUOp        out  3  000 add,001 sub,010 use func,011 and,100 or
//  PCSource out 2 (00 ALU,01 ALUOut,10 jump tgt,11 rs); PCWrite, PCWriteCond out 1
//  BranchNe     out  1  invert the zero condition for PCWriteCond
//  Illegal      out  1  one-cycle pulse: undecodable opcode
//  state        out  STATE_W  current state, for debug
// BEHAVIOUR
//  - Moore outputs decoded from the state register; unlisted outputs are 0.
//    IRWrite/PCWrite in FETCH are qualified by mem_ready (Mealy).
//  - Reset: state goes to IDLE immediately (async). All outputs are 0 in IDLE.
//    Applies mid-instruction too; a partial instruction is abandoned.
//  IDLE(0)   -> FETCH on first edge after reset deasserts.
//  FETCH(1)  MemRead=1 IorD=0 ALUSrcA=0 ALUSrcB=01 ALUOp=000 PCSource=00
//            IRWrite=PCWrite=mem_ready; -> DECODE if mem_ready, else stay.
//  DECODE(2) ALUSrcB=11 ALUOp=000.
//            LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP,
//            ADDI/ANDI/ORI->IEXEC; other opcodes: Illegal=1 -> FETCH.
//  MEMADR(3) ALUSrcA=1 ALUSrcB=10 ALUOp=000; LW->MEMRD, SW->MEMWR.
//  MEMRD(4)  MemRead=1 IorD=1; hold until mem_ready, then -> MEMWB.
//  MEMWB(5)  RegWrite=1 MemtoReg=1 RegDst=0 -> FETCH.
//  MEMWR(6)  MemWrite=1 IorD=1; hold until mem_ready, then -> FETCH.
//  EXEC(7)   ALUSrcA=1 ALUSrcB=00 ALUOp=010.
//            If JumpReg: PCWrite=1 PCSource=11 -> FETCH; else -> RWB.
//  RWB(8)    RegWrite=1 RegDst=1 ALUOp=010 -> FETCH.
//  BRANCH(9) ALUSrcA=1 ALUSrcB=00 ALUOp=001 PCWriteCond=1 PCSource=01 -> FETCH.
//  JUMP(10)  PCWrite=1 PCSource=10 -> FETCH.
//  IEXEC(11) ALUSrcA=1 ALUSrcB=10.
//            ALUOp=000 for ADDI, 011 for ANDI, 100 for ORI.
//            ZeroExt=1 for ANDI/ORI -> IWB.
//  IWB(12)   RegWrite=1 RegDst=0 MemtoReg=0; ALUOp/ZeroExt held from IEXEC -> FETCH.
//  - Codes 13..15 unreachable; if entered, they decode as IDLE (all outputs 0) -> FETCH.
//  - Cycle counts with no stalls: lw 5, sw 4, R-type 4, jr 3, beq 3, j 3, imm 4.
//  - mem_ready is ignored outside the three memory states.
//    A mem_ready held high gives zero wait states.
// CONFIGURATION
//  BNE_EN defined: OP_BNE in DECODE -> BRANCH with BranchNe=1 in BRANCH.
//  BNE_EN undefined: BranchNe is tied 0; OP_BNE is illegal (Illegal pulse, -> FETCH).
// TESTING
//  T1 reset=1 for 2 cycles -> all outputs 0, state=0; release -> state=1 after 1 edge.
//  T2 lw (6'h23), mem_ready low 2 cycles in FETCH and MEMRD -> FETCH held 3 cycles,
//     IRWrite=1 only on the last; MEMRD held 3 cycles; MEMWB RegWrite=MemtoReg=1 for 1 cycle.
//  T3 Opcode=6'h00, JumpReg=1 -> EXEC: PCWrite=1 PCSource=11; next FETCH; RegWrite never 1.
//  T4 ori (6'h0D) -> IEXEC ALUOp=100 ZeroExt=1; IWB RegWrite=1 RegDst=0; then FETCH.
//  T5 Opcode=6'h3F -> Illegal=1 for one cycle in DECODE, then FETCH.
//     Opcode=6'h05 -> BRANCH with BranchNe=1 if BNE_EN, else Illegal.
//  T6 reset asserted mid-MEMWR, off clock edge -> MemWrite=0 and state=0 immediately.

Source files
------------

// File: rtl/multicycle_main_cu_if.sv
// Control bundle between the multi-cycle main control FSM and the datapath/memory.
// master = control unit side, slave = datapath side.
interface multicycle_main_cu_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Opcode;
    logic               JumpReg;
    logic               mem_ready;
    logic               MemRead;
    logic               MemWrite;
    logic               IorD;
    logic               IRWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               ZeroExt;
    logic [2:0]         ALUOp;
    logic [1:0]         PCSource;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               BranchNe;
    logic               Illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  Opcode, JumpReg, mem_ready,
        output MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ZeroExt, ALUOp, PCSource, PCWrite, PCWriteCond,
               BranchNe, Illegal, state
    );

    modport slave (
        output Opcode, JumpReg, mem_ready,
        input  MemRead, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ZeroExt, ALUOp, PCSource, PCWrite, PCWriteCond,
               BranchNe, Illegal, state
    );
endinterface

// File: rtl/multicycle_main_cu.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional macro BNE_EN adds bne support (DECODE -> BRANCH with BranchNe asserted).
module multicycle_main_cu #(
    parameter int         STATE_W  = 4,
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_ANDI  = 6'h0C,
    parameter logic [5:0] OP_ORI   = 6'h0D,
    parameter logic [5:0] OP_BNE   = 6'h05
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_main_cu_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = STATE_W'(0),
        S_FETCH  = STATE_W'(1),
        S_DECODE = STATE_W'(2),
        S_MEMADR = STATE_W'(3),
        S_MEMRD  = STATE_W'(4),
        S_MEMWB  = STATE_W'(5),
        S_MEMWR  = STATE_W'(6),
        S_EXEC   = STATE_W'(7),
        S_RWB    = STATE_W'(8),
        S_BRANCH = STATE_W'(9),
        S_JUMP   = STATE_W'(10),
        S_IEXEC  = STATE_W'(11),
        S_IWB    = STATE_W'(12)
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    assign bus.state = r_state;

    always_comb begin
        w_next          = r_state;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IorD        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ZeroExt     = 1'b0;
        bus.ALUOp       = 3'b000;
        bus.PCSource    = 2'b00;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.Illegal     = 1'b0;

        case (r_state)
            S_IDLE: w_next = S_FETCH;

            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                if (bus.mem_ready) w_next = S_DECODE;
            end

            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW:             w_next = S_MEMADR;
                    OP_RTYPE:                 w_next = S_EXEC;
                    OP_BEQ:                   w_next = S_BRANCH;
`ifdef BNE_EN
                    OP_BNE:                   w_next = S_BRANCH;
`endif
                    OP_J:                     w_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IEXEC;
                    default: begin
                        bus.Illegal = 1'b1;
                        w_next      = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                w_next      = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end

            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                w_next       = S_FETCH;
            end

            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) w_next = S_FETCH;
            end

            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 3'b010;
                if (bus.JumpReg) begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b11;
                    w_next       = S_FETCH;
                end else begin
                    w_next = S_RWB;
                end
            end

            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                bus.ALUOp    = 3'b010;
                w_next       = S_FETCH;
            end

            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 3'b001;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
`ifdef BNE_EN
                bus.BranchNe    = (bus.Opcode == OP_BNE);
`endif
                w_next          = S_FETCH;
            end

            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                w_next       = S_FETCH;
            end

            // IWB re-decodes the stable opcode so the ALU result stays valid for writeback.
            S_IEXEC, S_IWB: begin
                if (r_state == S_IEXEC) begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    w_next      = S_IWB;
                end else begin
                    bus.RegWrite = 1'b1;
                    w_next       = S_FETCH;
                end
                if (bus.Opcode == OP_ANDI) begin
                    bus.ALUOp   = 3'b011;
                    bus.ZeroExt = 1'b1;
                end else if (bus.Opcode == OP_ORI) begin
                    bus.ALUOp   = 3'b100;
                    bus.ZeroExt = 1'b1;
                end
            end

            default: w_next = S_FETCH;
        endcase
    end

endmodule
